// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / block fill initiator on the data-memory port.
// Copies pick a descending word order when the destination overlaps the tail
// of the source, so a forward-overlapping block is moved without corruption.
// Commands that would touch addresses at or beyond DEPTH are rejected before
// any memory access. All outputs come straight from flops.
module mem_copy_engine #(
    parameter int DEPTH = 64,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [LEN_W-1:0]   idx_r, idx_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic               mode_r, mode_s;
    logic               desc_r, desc_s;
    logic               err_flag_r, err_flag_s;
    logic [31:0]        src_r, src_s;
    logic [31:0]        dst_r, dst_s;
    logic [31:0]        fill_r, fill_s;
    logic [31:0]        data_r, data_s;

    // Next values of the output flops, decoded from the next state/fields.
    logic               busy_s, done_s, err_s, mem_re_s, mem_we_s;
    logic [31:0]        mem_addr_s, mem_wdata_s;

    // Command checks, evaluated in 33 bits so an address near 2^32 cannot wrap.
    logic [32:0]        src_end_s, dst_end_s;
    logic               range_bad_s, overlap_s, last_s;

    // Command-time range and overlap checks, plus last-word detection.
    always_comb begin
        src_end_s   = {1'b0, src_addr} + 33'(length);
        dst_end_s   = {1'b0, dst_addr} + 33'(length);
        range_bad_s = ((mode == 1'b0) && (src_end_s > 33'(DEPTH))) ||
                      (dst_end_s > 33'(DEPTH));
        overlap_s   = (mode == 1'b0) && (dst_addr > src_addr) &&
                      ({1'b0, dst_addr} < src_end_s);
        if (desc_r) begin
            last_s = (idx_r == {LEN_W{1'b0}});
        end else begin
            last_s = (idx_r == (len_r - LEN_W'(1)));
        end
    end

    // Next-state logic: command capture, word stepping and data capture.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        len_s      = len_r;
        mode_s     = mode_r;
        desc_s     = desc_r;
        err_flag_s = err_flag_r;
        src_s      = src_r;
        dst_s      = dst_r;
        fill_s     = fill_r;
        data_s     = data_r;
        case (state_r)
            ST_IDLE: begin
                err_flag_s = 1'b0;
                if (start) begin
                    mode_s = mode;
                    src_s  = src_addr;
                    dst_s  = dst_addr;
                    len_s  = length;
                    fill_s = fill_value;
                    desc_s = overlap_s;
                    if (range_bad_s) begin
                        err_flag_s = 1'b1;
                        state_s    = ST_DONE;
                    end else if (length == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = overlap_s ? (length - LEN_W'(1)) : {LEN_W{1'b0}};
                        state_s = mode ? ST_WRITE : ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                data_s  = mem_rdata;
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = desc_r ? (idx_r - LEN_W'(1)) : (idx_r + LEN_W'(1));
                    state_s = mode_r ? ST_WRITE : ST_READ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be held in flops.
    always_comb begin
        busy_s      = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        mem_re_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = 32'd0;
        mem_wdata_s = 32'd0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_READ: begin
                busy_s     = 1'b1;
                mem_re_s   = 1'b1;
                mem_addr_s = src_s + 32'(idx_s);
            end
            ST_WRITE: begin
                busy_s      = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = dst_s + 32'(idx_s);
                mem_wdata_s = mode_s ? fill_s : data_s;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
                err_s  = err_flag_s;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, command fields, data register and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {LEN_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            mode_r     <= 1'b0;
            desc_r     <= 1'b0;
            err_flag_r <= 1'b0;
            src_r      <= 32'd0;
            dst_r      <= 32'd0;
            fill_r     <= 32'd0;
            data_r     <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            len_r      <= len_s;
            mode_r     <= mode_s;
            desc_r     <= desc_s;
            err_flag_r <= err_flag_s;
            src_r      <= src_s;
            dst_r      <= dst_s;
            fill_r     <= fill_s;
            data_r     <= data_s;
            busy       <= busy_s;
            done       <= done_s;
            err        <= err_s;
            mem_re     <= mem_re_s;
            mem_we     <= mem_we_s;
            mem_addr   <= mem_addr_s;
            mem_wdata  <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed bench with a behavioural 64-word memory and an
// access scoreboard filled from a reference model when each command is issued.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [6:0]  length;
    logic [31:0] fill_value;
    logic        busy, done, err;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] exp_mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t sb_q[$];

    int checks = 0;
    int errors = 0;

    mem_copy_engine #(.DEPTH(64), .LEN_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: preload port for the bench, write port for the engine.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_we && (mem_addr < 32'd64)) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        if (mem_addr < 32'd64) mem_rdata = mem[mem_addr[5:0]];
        else                   mem_rdata = 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic load(input int a, input logic [31:0] v);
        pl_en   = 1'b1;
        pl_addr = 6'(a);
        pl_data = v;
        exp_mem[a] = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference model: pushes the expected access sequence of a valid command.
    task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input int n, input logic [31:0] f);
        logic desc;
        int   i;
        logic [31:0] v;
        desc = (m == 1'b0) && (d > s) && (d < s + 32'(n));
        for (int st = 0; st < n; st++) begin
            i = desc ? (n - 1 - st) : st;
            if (m == 1'b0) begin
                sb_q.push_back('{we: 1'b0, addr: s + 32'(i), data: 32'd0});
                v = exp_mem[s + 32'(i)];
            end else begin
                v = f;
            end
            sb_q.push_back('{we: 1'b1, addr: d + 32'(i), data: v});
            exp_mem[d + 32'(i)] = v;
        end
    endtask

    // Issue one command and watch it to completion against the scoreboard.
    task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [6:0] n, input logic [31:0] f,
                           input int exp_k, input logic exp_err, input logic noise);
        int   k;
        bit   seen;
        acc_t e;
        mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
        start = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            chk("re_we_excl", {31'd0, mem_re & mem_we}, 32'd0);
            if (mem_re || mem_we) begin
                chk("sb_extra", sb_q.size(), (sb_q.size() == 0) ? 32'd1 : 32'(sb_q.size()));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("acc_addr", mem_addr, e.addr);
                    if (e.we) chk("acc_wdata", mem_wdata, e.data);
                end
            end
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", k, exp_k);
                chk("done_err", {31'd0, err}, {31'd0, exp_err});
                chk("done_busy", {31'd0, busy}, 32'd1);
                chk("sb_drained", sb_q.size(), 32'd0);
            end
            start = noise;
            mode = 1'($urandom);
            src_addr = $urandom_range(0, 63);
            dst_addr = $urandom_range(0, 63);
            length = 7'($urandom_range(1, 8));
            fill_value = $urandom;
        end
        if (!seen) chk("done_timeout", k, exp_k);
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_access", {30'd0, mem_re, mem_we}, 32'd0);
        @(negedge clk);
        chk("idle_busy2", {31'd0, busy}, 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int  nw;
        bit  act;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = 32'd0; dst_addr = 32'd0;
        length = 7'd0; fill_value = 32'd0; pl_en = 1'b0; pl_addr = 6'd0; pl_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_re_we", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 64; a++) load(a, 32'd0);

        // Ascending copy 0 -> 8, three words.
        load(0, 32'd7); load(1, 32'd8); load(2, 32'd9);
        model(1'b0, 32'd0, 32'd8, 3, 32'd0);
        run_cmd(1'b0, 32'd0, 32'd8, 7'd3, 32'd0, 7, 1'b0, 1'b0);
        chk("copy_m8", mem[8], 32'd7);
        chk("copy_m9", mem[9], 32'd8);
        chk("copy_m10", mem[10], 32'd9);

        // Fill to the very top of memory.
        model(1'b1, 32'd0, 32'd60, 4, 32'hDEADBEEF);
        run_cmd(1'b1, 32'd0, 32'd60, 7'd4, 32'hDEADBEEF, 5, 1'b0, 1'b0);
        for (int a = 60; a < 64; a++) chk("fill_top", mem[a], 32'hDEADBEEF);

        // Forward-overlapping copy must run descending.
        load(2, 32'd1); load(3, 32'd2); load(4, 32'd3); load(5, 32'd4);
        model(1'b0, 32'd2, 32'd4, 4, 32'd0);
        run_cmd(1'b0, 32'd2, 32'd4, 7'd4, 32'd0, 9, 1'b0, 1'b0);
        chk("ovl_m4", mem[4], 32'd1);
        chk("ovl_m5", mem[5], 32'd2);
        chk("ovl_m6", mem[6], 32'd3);
        chk("ovl_m7", mem[7], 32'd4);

        // Rejected command, then zero length: no accesses, done one cycle on.
        run_cmd(1'b0, 32'd0, 32'd62, 7'd4, 32'd0, 1, 1'b1, 1'b0);
        run_cmd(1'b0, 32'd0, 32'd62, 7'd0, 32'd0, 1, 1'b0, 1'b0);
        // Source near 2^32 must not wrap into range.
        run_cmd(1'b0, 32'hFFFF_FFFE, 32'd0, 7'd4, 32'd0, 1, 1'b1, 1'b0);
        // Fill ignores the source address.
        model(1'b1, 32'd1000, 32'd30, 2, 32'h0000_1234);
        run_cmd(1'b1, 32'd1000, 32'd30, 7'd2, 32'h0000_1234, 3, 1'b0, 1'b0);
        chk("fill_nosrc", mem[31], 32'h0000_1234);

        // Start pulses during the transfer and in DONE are ignored.
        model(1'b0, 32'd8, 32'd16, 3, 32'd0);
        run_cmd(1'b0, 32'd8, 32'd16, 7'd3, 32'd0, 7, 1'b0, 1'b1);
        chk("noise_m16", mem[16], 32'd7);
        chk("noise_m17", mem[17], 32'd8);
        chk("noise_m18", mem[18], 32'd9);

        // Reset after two writes of a five-word fill.
        mode = 1'b1; src_addr = 32'd0; dst_addr = 32'd20; length = 7'd5;
        fill_value = 32'h0000_0055; start = 1'b1;
        nw = 0;
        for (int c = 0; c < 20 && nw < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we) begin
                chk("rst_fill_addr", mem_addr, 32'd20 + 32'(nw));
                nw++;
            end
        end
        chk("rst_fill_writes", nw, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flags", {28'd0, done, err, mem_re, mem_we}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        act = 1'b0;
        repeat (8) begin
            @(negedge clk);
            act = act | mem_we | mem_re | done | busy;
        end
        chk("abort_quiet", {31'd0, act}, 32'd0);
        chk("abort_m20", mem[20], 32'h0000_0055);
        chk("abort_m21", mem[21], 32'h0000_0055);
        chk("abort_m22", mem[22], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
